// File: rtl/div_sequencer.sv
// Control stage wrapped around an iterative unsigned divider: it strips operand signs, starts the
// divider, waits for done with a timeout, reapplies signs and holds the result for the consumer.
module div_sequencer #(
    parameter int unsigned N             = 4,
    parameter int unsigned TIMEOUT_SLACK = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         in_signed_i,
    input  logic [N-1:0] in_dividend_i,
    input  logic [N-1:0] in_divisor_i,
    output logic         div_load_o,
    output logic [N-1:0] div_dividend_o,
    output logic [N-1:0] div_divisor_o,
    input  logic [N-1:0] div_q_i,
    input  logic [N-1:0] div_r_i,
    input  logic         div_done_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_quot_o,
    output logic [N-1:0] out_rem_o,
    output logic         out_dz_o,
    output logic         out_ovf_o,
    output logic         out_err_o
);

    localparam int unsigned TimeoutCnt = N + TIMEOUT_SLACK;
    localparam int unsigned TW         = $clog2(TimeoutCnt + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StOut} state_e;

    state_e         state_q, state_d;
    logic           signed_q, signed_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;

    logic           neg_quot;
    logic           neg_rem;
    logic           ovf_case;

    // -2^(N-1) negates onto itself, which reads as 2^(N-1) when taken unsigned.
    function automatic logic [N-1:0] magnitude(input logic is_signed, input logic [N-1:0] x);
        return (is_signed && x[N-1]) ? -x : x;
    endfunction

    assign neg_quot = signed_q & (dvd_q[N-1] ^ dvs_q[N-1]);
    assign neg_rem  = signed_q & dvd_q[N-1];
    assign ovf_case = signed_q && (dvd_q == {1'b1, {(N-1){1'b0}}}) && (dvs_q == '1);

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        timer_d  = timer_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    signed_d = in_signed_i;
                    dvd_d    = in_dividend_i;
                    dvs_d    = in_divisor_i;
                    dz_d     = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    if (in_divisor_i == '0) begin
                        quot_d  = '1;
                        rem_d   = in_dividend_i;
                        dz_d    = 1'b1;
                        state_d = StOut;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                timer_d = '0;
                state_d = StRun;
            end
            StRun: begin
                if (div_done_i) begin
                    quot_d  = neg_quot ? -div_q_i : div_q_i;
                    rem_d   = neg_rem ? -div_r_i : div_r_i;
                    ovf_d   = ovf_case;
                    state_d = StOut;
                end else if (timer_q == TW'(TimeoutCnt)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = StOut;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            signed_q <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            timer_q  <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            timer_q  <= timer_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Gate with reset so no request is accepted while reset is still held.
    assign in_ready_o     = (state_q == StIdle) && !rst_i;
    assign div_load_o     = (state_q == StLoad);
    assign div_dividend_o = magnitude(signed_q, dvd_q);
    assign div_divisor_o  = magnitude(signed_q, dvs_q);
    assign out_valid_o    = (state_q == StOut);
    assign out_quot_o     = quot_q;
    assign out_rem_o      = rem_q;
    assign out_dz_o       = dz_q;
    assign out_ovf_o      = ovf_q;
    assign out_err_o      = err_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed and random requests against an arithmetic reference model,
// with a behavioural divider whose done latency is set per request.
module tb_div_sequencer;

    localparam int N     = 4;
    localparam int SLACK = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_signed = 1'b0;
    logic [N-1:0] in_dividend = '0;
    logic [N-1:0] in_divisor = '0;
    logic         div_load;
    logic [N-1:0] div_dividend, div_divisor;
    logic [N-1:0] div_q = '0, div_r = '0;
    logic         div_done;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_quot, out_rem;
    logic         out_dz, out_ovf, out_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_sequencer #(.N(N), .TIMEOUT_SLACK(SLACK)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_signed_i    (in_signed),
        .in_dividend_i  (in_dividend),
        .in_divisor_i   (in_divisor),
        .div_load_o     (div_load),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_q_i        (div_q),
        .div_r_i        (div_r),
        .div_done_i     (div_done),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_quot_o     (out_quot),
        .out_rem_o      (out_rem),
        .out_dz_o       (out_dz),
        .out_ovf_o      (out_ovf),
        .out_err_o      (out_err)
    );

    // Divider stand-in: done rises lat cycles after the first RUN cycle, cleared by load.
    int lat = N;
    int dcnt = 0;
    bit dact = 1'b0;
    always @(posedge clk) begin
        if (div_load) begin
            dact  <= 1'b1;
            dcnt  <= 0;
            div_q <= div_dividend / div_divisor;
            div_r <= div_dividend % div_divisor;
        end else if (dact) begin
            dcnt <= dcnt + 1;
        end
    end
    assign div_done = dact && !div_load && (dcnt >= lat);

    typedef struct {
        logic [N-1:0] q, r, ma, mb;
        logic         dz, ovf, err;
        int           cyc;
    } exp_t;

    function automatic exp_t model(bit s, int a, int b, int l);
        exp_t e;
        int sa, sb, q, r;
        sa = (s && a >= 8) ? a - 16 : a;
        sb = (s && b >= 8) ? b - 16 : b;
        e.ma = N'(sa < 0 ? -sa : sa);
        e.mb = N'(sb < 0 ? -sb : sb);
        e.dz = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
        if (b == 0) begin
            e.q = '1; e.r = N'(a); e.dz = 1'b1; e.cyc = 1;
        end else if (l > N + SLACK) begin
            e.q = '0; e.r = '0; e.err = 1'b1; e.cyc = N + SLACK + 3;
        end else begin
            if (s && sa == -8 && sb == -1) begin
                q = -8; r = 0; e.ovf = 1'b1;
            end else begin
                q = sa / sb; r = sa % sb;
            end
            e.q = N'(q); e.r = N'(r); e.cyc = 3 + l;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int l, input int hold, input string tag);
        exp_t e;
        int c;
        e = model(s, int'(a), int'(b), l);
        lat = l;
        out_ready = (hold == 0);
        @(negedge clk);
        chk({tag, ".idle_ready"}, in_ready, 1);
        in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b;
        @(negedge clk);
        in_valid = 1'b0; in_dividend = N'($urandom); in_divisor = N'($urandom);
        c = 1;
        chk({tag, ".load"}, div_load, (b != 0));
        if (b != 0) begin
            chk({tag, ".op_a"}, div_dividend, e.ma);
            chk({tag, ".op_b"}, div_divisor, e.mb);
        end
        while (!out_valid && c < 30) begin
            @(negedge clk);
            c++;
            if (!out_valid) begin
                chk({tag, ".run_noload"}, div_load, 0);
                chk({tag, ".run_a"}, div_dividend, e.ma);
                chk({tag, ".busy_ready"}, in_ready, 0);
            end
        end
        chk({tag, ".latency"}, c, e.cyc);
        chk({tag, ".quot"}, out_quot, e.q);
        chk({tag, ".rem"}, out_rem, e.r);
        chk({tag, ".flags"}, {out_dz, out_ovf, out_err}, {e.dz, e.ovf, e.err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i < hold - 1);
            in_divisor = '0;
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_ready"}, in_ready, 0);
            chk({tag, ".hold_res"}, {out_quot, out_rem, out_dz, out_ovf, out_err},
                {e.q, e.r, e.dz, e.ovf, e.err});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".drop_valid"}, out_valid, 0);
        chk({tag, ".back_idle"}, in_ready, 1);
        chk({tag, ".flags_kept"}, {out_dz, out_ovf, out_err}, {e.dz, e.ovf, e.err});
    endtask

    initial begin
        #1;
        chk("rst.ready", in_ready, 0);
        chk("rst.outs", {div_load, div_dividend, div_divisor, out_valid, out_quot, out_rem},
            0);
        chk("rst.flags", {out_dz, out_ovf, out_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.first_idle", in_ready, 1);

        run_op(1'b0, 4'd13, 4'd3, N, 0, "u13_3");
        run_op(1'b1, 4'b1001, 4'b0010, N, 0, "sm7_2");
        run_op(1'b1, 4'b0111, 4'b1110, N, 0, "s7_m2");
        run_op(1'b0, 4'd9, 4'd0, N, 0, "dz9");
        run_op(1'b1, 4'b1000, 4'b1111, N, 0, "sm8_m1");
        run_op(1'b1, 4'b1000, 4'b0010, N, 0, "sm8_2");
        run_op(1'b0, 4'd13, 4'd3, 100, 5, "timeout");

        // Reset in the middle of RUN.
        lat = N;
        @(negedge clk);
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 4'd5; in_divisor = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.ready", in_ready, 0);
        chk("midrst.outs", {div_load, div_dividend, div_divisor, out_valid, out_quot, out_rem},
            0);
        chk("midrst.flags", {out_dz, out_ovf, out_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.idle", {in_ready, out_valid}, 2'b10);
        run_op(1'b0, 4'd6, 4'd2, N, 0, "u6_2");

        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            run_op(bit'($urandom_range(0, 1)), ra, rb, $urandom_range(0, N + SLACK + 1),
                   ($urandom_range(0, 3) == 0) ? 2 : 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
